// File: rtl/csr_master_pkg.sv
// Shared types for the CSR bus master: command opcodes, response status
// codes and the FSM state encoding.
package csr_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ILLEGAL = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDWAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/csr_master.sv
// Avalon-MM initiator that runs one write, read or poll-until-match command
// at a time against the register bank and returns a single response pulse.
module csr_master
  import csr_master_pkg::*;
#(
  parameter int N            = 32,
  parameter int ADDR_W       = 3,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_address,
  input  logic [N-1:0]         cmd_data,
  input  logic [N-1:0]         cmd_mask,
  input  logic [TIMEOUT_W-1:0] cmd_timeout,
  output logic                 rsp_valid,
  output logic [N-1:0]         rsp_data,
  output logic [1:0]           rsp_status,
  output logic [ADDR_W-1:0]    address,
  output logic                 read,
  output logic                 write,
  output logic [N-1:0]         writedata,
  input  logic [N-1:0]         readdata,
  input  logic                 waitrequest
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [N-1:0]         cmp_q, cmp_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]    address_q, address_d;
  logic [N-1:0]         writedata_q, writedata_d;
  logic [N-1:0]         rsp_data_q, rsp_data_d;
  status_e              rsp_status_q, rsp_status_d;
  logic                 lat_last;
  logic                 poll_match;
  logic                 timeout_hit;

  // The last RDWAIT cycle is the one whose closing edge samples readdata.
  assign lat_last    = (lat_q == LAT_W'(READ_LATENCY - 1));
  assign poll_match  = ((readdata ^ cmp_q) & mask_q) == '0;
  assign cnt_inc     = cnt_q + TIMEOUT_W'(1);
  // A zero limit never matches here, so the counter simply wraps and polling continues.
  assign timeout_hit = (timeout_q != '0) && (cnt_inc == timeout_q);

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;

  // State and registered outputs; reset aborts any transaction in flight without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      cmp_q        <= '0;
      mask_q       <= '0;
      timeout_q    <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cmp_q        <= cmp_d;
      mask_q       <= mask_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      read_q       <= read_d;
      write_q      <= write_d;
      rsp_valid_q  <= rsp_valid_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Next-state: command dispatch, bus handshakes, and the poll retry/finish decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_WRITE:         state_d = S_WRITE;
            OP_READ, OP_POLL: state_d = S_READ;
            default:          state_d = S_RESP;
          endcase
        end
      end
      S_WRITE: if (!waitrequest) state_d = S_RESP;
      S_READ:  if (!waitrequest) state_d = S_RDWAIT;
      S_RDWAIT: begin
        if (lat_last) begin
          if (op_q == OP_READ || poll_match || timeout_hit) state_d = S_RESP;
          else                                              state_d = S_READ;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; strobes and rsp_valid follow the state being entered.
  always_comb begin
    op_d         = op_q;
    cmp_d        = cmp_q;
    mask_d       = mask_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    lat_d        = '0;
    address_d    = address_q;
    writedata_d  = writedata_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    read_d       = (state_d == S_READ);
    write_d      = (state_d == S_WRITE);
    rsp_valid_d  = (state_d == S_RESP);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = op_e'(cmd_op);
          cmp_d     = cmd_data;
          mask_d    = cmd_mask;
          timeout_d = cmd_timeout;
          cnt_d     = '0;
          if (op_e'(cmd_op) != OP_ILLEGAL) address_d    = cmd_address;
          if (op_e'(cmd_op) == OP_WRITE)   writedata_d  = cmd_data;
          if (op_e'(cmd_op) == OP_ILLEGAL) rsp_status_d = ST_ILLEGAL;
        end
      end
      S_WRITE: begin
        if (!waitrequest) begin
          rsp_data_d   = writedata_q;
          rsp_status_d = ST_OK;
        end
      end
      S_RDWAIT: begin
        if (lat_last) begin
          rsp_data_d   = readdata;
          rsp_status_d = ST_OK;
          if (op_q != OP_READ && !poll_match) begin
            cnt_d = cnt_inc;
            if (timeout_hit) rsp_status_d = ST_TIMEOUT;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
